// File: rtl/bp_16_8_enc.sv
// bp_16_8_enc: (16,8) polar encoder feeding the bp_16_8 decoder.
// Loads 8 info bits onto the fixed information set and runs one F butterfly
// stage per cycle. It then emits the codeword and the noiseless signed LLRs,
// packed four bytes to a word.
// Optional build macro: BP_ENC_ERR_INJECT_EN adds err_mask, which flips
// selected LLR signs. The codeword itself is not changed.

// Per-lane LLR mapper: a 0 bit gives +LLR_MAG and a 1 bit gives -LLR_MAG.
// The sign is taken after the optional flip.
module bp_16_8_enc_lane #(
    parameter logic [7:0] LLR_MAG = 8'd1
) (
    input  logic       cbit,
    input  logic       flip,
    output logic [7:0] llr
);
    assign llr = (cbit ^ flip) ? (~LLR_MAG + 8'd1) : LLR_MAG;
endmodule

module bp_16_8_enc #(
    parameter logic [7:0] LLR_MAG = 8'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  info,
`ifdef BP_ENC_ERR_INJECT_EN
    input  logic [15:0] err_mask,
`endif
    output logic        en_busy,
    output logic        done,
    output logic [15:0] code_out,
    output logic [31:0] llr_w0,
    output logic [31:0] llr_w1,
    output logic [31:0] llr_w2,
    output logic [31:0] llr_w3
);
    localparam int NUM_LANES = 16;

    typedef enum logic [2:0] {IDLE, ST0, ST1, ST2, ST3, OUT} state_t;

    state_t                       state;
    logic [NUM_LANES-1:0]         v;      // v[i] = 0-indexed u/x bit i
    logic [NUM_LANES-1:0]         u_load;
    logic [NUM_LANES-1:0]         cw;     // codeword, x1 at MSB
    logic [NUM_LANES-1:0]         flip;   // per 0-indexed bit
    logic [NUM_LANES-1:0][7:0]    llr_nxt; // LLR_1 at the top byte
`ifdef BP_ENC_ERR_INJECT_EN
    logic [NUM_LANES-1:0]         emask;
`endif

    // Information set is u8, u10..u16 (0-indexed 7, 9..15). All other bits are frozen to 0.
    assign u_load = {info[0], info[1], info[2], info[3], info[4], info[5],
                     info[6], 1'b0, info[7], 7'b0};

    // One butterfly stage. The upper half of each pair absorbs its partner
    // 2^s positions away.
    function automatic logic [15:0] bfly(input logic [15:0] a, input int s);
        logic [15:0] r;
        r = a;
        for (int i = 0; i < 16; i++)
            if (((i >> s) & 1) == 0)
                r[i] = a[i] ^ a[4'(i | (1 << s))];
        return r;
    endfunction

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign cw[NUM_LANES-1-i] = v[i];
`ifdef BP_ENC_ERR_INJECT_EN
        assign flip[i] = emask[NUM_LANES-1-i];
`else
        assign flip[i] = 1'b0;
`endif
        bp_16_8_enc_lane #(.LLR_MAG(LLR_MAG)) u_lane (
            .cbit (v[i]),
            .flip (flip[i]),
            .llr  (llr_nxt[NUM_LANES-1-i])
        );
    end

    // Sequencer: load, four butterfly stages, then register outputs and pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            v        <= '0;
            en_busy  <= 1'b0;
            done     <= 1'b0;
            code_out <= '0;
            llr_w0   <= '0;
            llr_w1   <= '0;
            llr_w2   <= '0;
            llr_w3   <= '0;
`ifdef BP_ENC_ERR_INJECT_EN
            emask    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    v       <= u_load;
`ifdef BP_ENC_ERR_INJECT_EN
                    emask   <= err_mask;
`endif
                    en_busy <= 1'b1;
                    state   <= ST0;
                end
                ST0: begin v <= bfly(v, 0); state <= ST1; end
                ST1: begin v <= bfly(v, 1); state <= ST2; end
                ST2: begin v <= bfly(v, 2); state <= ST3; end
                ST3: begin v <= bfly(v, 3); state <= OUT; end
                OUT: begin
                    code_out <= cw;
                    llr_w0   <= llr_nxt[15:12];
                    llr_w1   <= llr_nxt[11:8];
                    llr_w2   <= llr_nxt[7:4];
                    llr_w3   <= llr_nxt[3:0];
                    done     <= 1'b1;
                    en_busy  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
